// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add multiplier, one multiplier bit per clock
// Optional two's-complement operands when MULT_SIGNED_EN is defined (adds the tc port).
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_SIGNED_EN
  input  logic                 tc,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic [2*WIDTH-1:0]   partial;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 last_bit;
  logic                 accept;

`ifdef MULT_SIGNED_EN
  logic                 sign_q, sign_d;
  logic                 neg_a;
  logic                 neg_b;

  // Magnitude of the most negative value still fits in WIDTH unsigned bits.
  assign neg_a = tc & a[WIDTH-1];
  assign neg_b = tc & b[WIDTH-1];
  assign a_mag = neg_a ? (~a + WIDTH'(1)) : a;
  assign b_mag = neg_b ? (~b + WIDTH'(1)) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign partial  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == BUSY);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
`ifdef MULT_SIGNED_EN
    sign_d   = sign_q;
`endif
    if (accept) begin
      mcand_d  = {{WIDTH{1'b0}}, a_mag};
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
`ifdef MULT_SIGNED_EN
      sign_d   = neg_a ^ neg_b;
`endif
    end else if (state_q == BUSY) begin
      acc_d    = partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last_bit) begin
`ifdef MULT_SIGNED_EN
        y_d = sign_q ? (~partial + (2*WIDTH)'(1)) : partial;
`else
        y_d = partial;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
`ifdef MULT_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
`ifdef MULT_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign y = y_q;

endmodule
